// File: rtl/chimp_pkg.sv
// Shared definitions for the chimp-test sequencer and the board renderer.
package chimp_pkg;

   localparam int DEF_GRID_SIZE     = 9;
   localparam int DEF_SAMPLE_PERIOD = 14;
   localparam int DEF_MAX_TRIES     = 8;
   localparam int POS_W             = 4;

   typedef logic [POS_W-1:0] pos_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CHECK,
      ST_EMIT,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/chimp_seq_gen_if.sv
// Position stream from the sequencer to the tile renderer (valid/ready).
interface chimp_seq_gen_if;
   import chimp_pkg::*;

   logic pos_valid;
   logic pos_ready;
   pos_t pos;
   pos_t pos_idx;

   modport master (output pos_valid, output pos, output pos_idx, input pos_ready);
   modport slave  (input pos_valid, input pos, input pos_idx, output pos_ready);

endinterface

// File: rtl/lowest_free_cell.sv
// Priority encoder: index of the lowest clear bit in the occupancy bitmap.
module lowest_free_cell
   import chimp_pkg::*;
#(
   parameter int GRID_SIZE = DEF_GRID_SIZE
) (
   input  logic [GRID_SIZE-1:0] bitmap,
   output pos_t                 index
);

   always_comb begin
      index = '0;
      for (int i = GRID_SIZE - 1; i >= 0; i--) begin
         if (!bitmap[i]) begin
            index = pos_t'(i);
         end
      end
   end

endmodule

// File: rtl/chimp_seq_gen.sv
// Builds one chimp-test round: samples the LFSR, rejects repeats, streams distinct positions.
module chimp_seq_gen
   import chimp_pkg::*;
#(
   parameter int GRID_SIZE     = DEF_GRID_SIZE,
   parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
   parameter int MAX_TRIES     = DEF_MAX_TRIES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  pos_t            count,
   input  pos_t            lfsr_rnd,
   output pos_t            lfsr_bound,
   chimp_seq_gen_if.master bus,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int PER_W   = $clog2(SAMPLE_PERIOD);
   localparam int TRIES_W = $clog2(MAX_TRIES + 1);

   seq_state_t           state_reg, state_next;
   pos_t                 count_reg, count_next;
   pos_t                 idx_reg, idx_next;
   pos_t                 cand_reg, cand_next;
   pos_t                 pos_reg, pos_next;
   pos_t                 pos_idx_reg, pos_idx_next;
   logic [PER_W-1:0]     per_reg, per_next;
   logic [TRIES_W-1:0]   tries_reg, tries_next;
   logic [GRID_SIZE-1:0] bitmap_reg, bitmap_next;
   logic                 pos_valid_reg, pos_valid_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic                 err_reg, err_next;

   pos_t        free_idx;
   pos_t        pick;
   logic [15:0] bitmap_pad;
   logic        cand_free;
   logic        count_ok;
   logic        tries_out;
   logic        last_pos;

   lowest_free_cell #(.GRID_SIZE(GRID_SIZE)) u_free (
      .bitmap (bitmap_reg),
      .index  (free_idx)
   );

   // Padding keeps the occupancy lookup in range for any 4-bit candidate.
   assign bitmap_pad = 16'(bitmap_reg);
   assign cand_free  = ({1'b0, cand_reg} < 5'(GRID_SIZE)) && !bitmap_pad[cand_reg];
   assign count_ok   = (count != '0) && ({1'b0, count} <= 5'(GRID_SIZE));
   assign tries_out  = (tries_reg == TRIES_W'(MAX_TRIES - 1));
   assign pick       = cand_free ? cand_reg : free_idx;
   assign last_pos   = (idx_reg == count_reg - 4'd1);

   assign lfsr_bound    = pos_t'(GRID_SIZE);
   assign bus.pos_valid = pos_valid_reg;
   assign bus.pos       = pos_reg;
   assign bus.pos_idx   = pos_idx_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign err           = err_reg;

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      idx_next       = idx_reg;
      cand_next      = cand_reg;
      pos_next       = pos_reg;
      pos_idx_next   = pos_idx_reg;
      per_next       = per_reg;
      tries_next     = tries_reg;
      bitmap_next    = bitmap_reg;
      pos_valid_next = pos_valid_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      err_next       = 1'b0;

      case (state_reg)
         // DONE also accepts start so a new round can begin while done is visible.
         ST_IDLE, ST_DONE: begin
            state_next = ST_IDLE;
            if (start) begin
               if (count_ok) begin
                  count_next  = count;
                  bitmap_next = '0;
                  idx_next    = '0;
                  tries_next  = '0;
                  per_next    = '0;
                  busy_next   = 1'b1;
                  state_next  = ST_WAIT;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (per_reg == PER_W'(SAMPLE_PERIOD - 1)) begin
               cand_next  = lfsr_rnd;
               per_next   = '0;
               state_next = ST_CHECK;
            end else begin
               per_next = per_reg + PER_W'(1);
            end
         end
         ST_CHECK: begin
            // After too many rejects the lowest free cell is taken instead.
            if (cand_free || tries_out) begin
               bitmap_next    = bitmap_reg | (GRID_SIZE'(1) << pick);
               pos_next       = pick;
               pos_idx_next   = idx_reg;
               pos_valid_next = 1'b1;
               tries_next     = '0;
               state_next     = ST_EMIT;
            end else begin
               tries_next = tries_reg + TRIES_W'(1);
               state_next = ST_WAIT;
            end
         end
         ST_EMIT: begin
            if (bus.pos_ready) begin
               pos_valid_next = 1'b0;
               if (last_pos) begin
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
                  state_next = ST_DONE;
               end else begin
                  idx_next   = idx_reg + 4'd1;
                  per_next   = '0;
                  state_next = ST_WAIT;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         count_reg     <= '0;
         idx_reg       <= '0;
         cand_reg      <= '0;
         pos_reg       <= '0;
         pos_idx_reg   <= '0;
         per_reg       <= '0;
         tries_reg     <= '0;
         bitmap_reg    <= '0;
         pos_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         idx_reg       <= idx_next;
         cand_reg      <= cand_next;
         pos_reg       <= pos_next;
         pos_idx_reg   <= pos_idx_next;
         per_reg       <= per_next;
         tries_reg     <= tries_next;
         bitmap_reg    <= bitmap_next;
         pos_valid_reg <= pos_valid_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

endmodule

// File: tb/tb_chimp_seq_gen.sv
// Scoreboard bench for chimp_seq_gen: scripted LFSR values, expected positions queued per round.
module tb_chimp_seq_gen;
   import chimp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   pos_t count = '0;
   pos_t lfsr_rnd = '0;
   pos_t lfsr_bound;
   logic busy, done, err;

   chimp_seq_gen_if bus();

   chimp_seq_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .count      (count),
      .lfsr_rnd   (lfsr_rnd),
      .lfsr_bound (lfsr_bound),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      pos_t pos;
      pos_t idx;
      int   cyc;
   } exp_t;

   exp_t sb_q[$];
   int   chg_off[$];
   pos_t chg_val[$];
   int   bp_lo, bp_hi, stray_rel, abort_rel;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input pos_t p, input pos_t i, input int c);
      exp_t e;
      e.pos = p;
      e.idx = i;
      e.cyc = c;
      sb_q.push_back(e);
   endtask

   task automatic sched(input int off, input pos_t v);
      chg_off.push_back(off);
      chg_val.push_back(v);
   endtask

   task automatic clear_setup();
      chg_off.delete();
      chg_val.delete();
      bp_lo     = 0;
      bp_hi     = -1;
      stray_rel = -1;
      abort_rel = -1;
   endtask

   // Cycle r is the r-th clock after the edge that accepted start.
   task automatic run_round(input pos_t cnt, input int exp_done, input int limit);
      bit prev_valid = 1'b0;
      bit seen_done = 1'b0;
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      count = cnt;
      @(negedge clk);
      start = 1'b0;
      for (int r = 1; r <= limit; r++) begin
         if (r > 1) @(negedge clk);
         while (chg_off.size() > 0 && chg_off[0] == r) begin
            lfsr_rnd = chg_val.pop_front();
            void'(chg_off.pop_front());
         end
         bus.pos_ready = !(r >= bp_lo && r <= bp_hi);
         start = (r == stray_rel);
         if (r == stray_rel) count = 4'd1;
         rst = (r != abort_rel);
         if (r == 1) chk("busy_after_start", busy, 1);
         if (r == abort_rel + 1) begin
            chk("abort_busy", busy, 0);
            chk("abort_valid", bus.pos_valid, 0);
         end
         if (bus.pos_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_valid", bus.pos_valid, 0);
            end else begin
               e = sb_q[0];
               if (!prev_valid) chk("valid_cycle", r, e.cyc);
               chk("pos", bus.pos, e.pos);
               chk("pos_idx", bus.pos_idx, e.idx);
               chk("busy_in_emit", busy, 1);
               if (bus.pos_ready) begin
                  $display("[TB] transfer pos=%0d idx=%0d cycle=%0d", bus.pos, bus.pos_idx, r);
                  void'(sb_q.pop_front());
               end
            end
         end
         prev_valid = bus.pos_valid;
         if (done) begin
            chk("done_cycle", r, exp_done);
            chk("busy_at_done", busy, 0);
            seen_done = 1'b1;
            break;
         end
      end
      start = 1'b0;
      rst = 1'b1;
      bus.pos_ready = 1'b1;
      if (seen_done) begin
         @(negedge clk);
         chk("done_width", done, 0);
      end else if (exp_done >= 0) begin
         chk("done_timeout", seen_done, 1);
      end else begin
         chk("no_done_after_abort", seen_done, 0);
      end
      chk("sb_drained", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic illegal(input pos_t cnt);
      @(negedge clk);
      start = 1'b1;
      count = cnt;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      $display("[TB] illegal count=%0d err=%0d", cnt, err);
      @(negedge clk);
      chk("err_width", err, 0);
      chk("err_busy_after", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.pos_ready = 1'b1;
      clear_setup();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.pos_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_pos", bus.pos, 0);
      chk("rst_pos_idx", bus.pos_idx, 0);
      chk("lfsr_bound", lfsr_bound, 9);
      rst = 1'b1;

      // Three first-try accepts.
      clear_setup();
      sched(1, 4'd4); sched(20, 4'd7); sched(36, 4'd1);
      push_exp(4'd4, 4'd0, 16); push_exp(4'd7, 4'd1, 32); push_exp(4'd1, 4'd2, 48);
      run_round(4'd3, 49, 80);

      // Duplicate rejected once.
      clear_setup();
      sched(1, 4'd5); sched(35, 4'd2);
      push_exp(4'd5, 4'd0, 16); push_exp(4'd2, 4'd1, 47);
      run_round(4'd2, 48, 80);

      // Stuck source: fallback after eight rejects each time.
      clear_setup();
      sched(1, 4'd0);
      push_exp(4'd0, 4'd0, 16); push_exp(4'd1, 4'd1, 137); push_exp(4'd2, 4'd2, 258);
      run_round(4'd3, 259, 320);

      // Out-of-range reject, then backpressure with a stray start.
      clear_setup();
      sched(1, 4'd11); sched(20, 4'd3); sched(40, 4'd6);
      bp_lo = 31; bp_hi = 50; stray_rel = 40;
      push_exp(4'd3, 4'd0, 31); push_exp(4'd6, 4'd1, 67);
      run_round(4'd2, 68, 100);

      clear_setup();
      illegal(4'd0);
      illegal(4'd10);

      // Abort during the second WAIT, then a fresh round.
      clear_setup();
      sched(1, 4'd7);
      abort_rel = 20;
      push_exp(4'd7, 4'd0, 16);
      run_round(4'd2, -1, 40);

      clear_setup();
      sched(1, 4'd7); sched(20, 4'd2);
      push_exp(4'd7, 4'd0, 16); push_exp(4'd2, 4'd1, 32);
      run_round(4'd2, 33, 60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
